// File: rtl/mem_req_scheduler_if.sv
// rtl/mem_req_scheduler_if.sv - requester-side and memory-side bundle for mem_req_scheduler
interface mem_req_scheduler_if #(
    parameter int NUM_REQS      = 4,
    parameter int DATA_WIDTH    = 512,
    parameter int ADDR_WIDTH    = 26,
    parameter int TAG_IN_WIDTH  = 8,
    parameter int LOG_REQS      = $clog2(NUM_REQS),
    parameter int TAG_OUT_WIDTH = TAG_IN_WIDTH + LOG_REQS
);
    logic [NUM_REQS-1:0]                  req_valid_in;
    logic [NUM_REQS-1:0]                  req_rw_in;
    logic [NUM_REQS*ADDR_WIDTH-1:0]       req_addr_in;
    logic [NUM_REQS*DATA_WIDTH/8-1:0]     req_byteen_in;
    logic [NUM_REQS*DATA_WIDTH-1:0]       req_data_in;
    logic [NUM_REQS*TAG_IN_WIDTH-1:0]     req_tag_in;
    logic [NUM_REQS-1:0]                  req_ready_in;

    logic [NUM_REQS-1:0]                  rsp_valid_in;
    logic [NUM_REQS*DATA_WIDTH-1:0]       rsp_data_in;
    logic [NUM_REQS*TAG_IN_WIDTH-1:0]     rsp_tag_in;
    logic [NUM_REQS-1:0]                  rsp_ready_in;

    logic                                 mem_req_valid_out;
    logic                                 mem_req_rw_out;
    logic [ADDR_WIDTH-1:0]                mem_req_addr_out;
    logic [DATA_WIDTH/8-1:0]              mem_req_byteen_out;
    logic [DATA_WIDTH-1:0]                mem_req_data_out;
    logic [TAG_OUT_WIDTH-1:0]             mem_req_tag_out;
    logic                                 mem_req_ready_out;

    logic                                 mem_rsp_valid_out;
    logic [DATA_WIDTH-1:0]                mem_rsp_data_out;
    logic [TAG_OUT_WIDTH-1:0]             mem_rsp_tag_out;
    logic                                 mem_rsp_ready_out;

    // Scheduler side
    modport slave (
        input  req_valid_in, req_rw_in, req_addr_in, req_byteen_in, req_data_in, req_tag_in,
        output req_ready_in,
        output rsp_valid_in, rsp_data_in, rsp_tag_in,
        input  rsp_ready_in,
        output mem_req_valid_out, mem_req_rw_out, mem_req_addr_out, mem_req_byteen_out,
        output mem_req_data_out, mem_req_tag_out,
        input  mem_req_ready_out,
        input  mem_rsp_valid_out, mem_rsp_data_out, mem_rsp_tag_out,
        output mem_rsp_ready_out
    );

    // Environment side: requesters plus downstream memory
    modport master (
        output req_valid_in, req_rw_in, req_addr_in, req_byteen_in, req_data_in, req_tag_in,
        input  req_ready_in,
        input  rsp_valid_in, rsp_data_in, rsp_tag_in,
        output rsp_ready_in,
        input  mem_req_valid_out, mem_req_rw_out, mem_req_addr_out, mem_req_byteen_out,
        input  mem_req_data_out, mem_req_tag_out,
        output mem_req_ready_out,
        output mem_rsp_valid_out, mem_rsp_data_out, mem_rsp_tag_out,
        input  mem_rsp_ready_out
    );
endinterface

// File: rtl/mem_req_scheduler.sv
// rtl/mem_req_scheduler.sv - round-robin memory request scheduler with per-requester read credits
module mem_req_scheduler #(
    parameter int NUM_REQS      = 4,
    parameter int DATA_WIDTH    = 512,
    parameter int ADDR_WIDTH    = 26,
    parameter int TAG_IN_WIDTH  = 8,
    parameter int MAX_PENDING   = 4,
    parameter int LOG_REQS      = $clog2(NUM_REQS),
    parameter int TAG_OUT_WIDTH = TAG_IN_WIDTH + LOG_REQS
) (
    input  logic clk,
    input  logic reset,
    mem_req_scheduler_if.slave bus
);
    localparam int BYTEEN_WIDTH = DATA_WIDTH / 8;
    localparam int CNT_WIDTH    = $clog2(MAX_PENDING + 1);

    logic [CNT_WIDTH-1:0] pend_cnt [NUM_REQS];
    logic [LOG_REQS-1:0]  last_ptr;
    logic [NUM_REQS-1:0]  eligible;
    logic [NUM_REQS-1:0]  grant_onehot;
    logic [NUM_REQS-1:0]  rsp_route;
    logic [NUM_REQS-1:0]  cnt_inc;
    logic [NUM_REQS-1:0]  cnt_dec;
    logic                 grant_any;
    logic [LOG_REQS-1:0]  grant_idx;
    logic                 stage_free;
    logic                 grant;
    logic [LOG_REQS-1:0]  rsp_idx;
    logic                 rsp_idx_ok;
    logic                 rsp_fire;

    // Requester may compete if it has a request and, for reads, a free credit
    always_comb begin
        eligible = '0;
        for (int i = 0; i < NUM_REQS; i++) begin
            eligible[i] = bus.req_valid_in[i] &&
                          (bus.req_rw_in[i] || (pend_cnt[i] < CNT_WIDTH'(MAX_PENDING)));
        end
    end

    // Round-robin search starting just after the last winner
    always_comb begin
        int                  cand;
        logic [LOG_REQS-1:0] cand_idx;
        cand      = 0;
        cand_idx  = '0;
        grant_any = 1'b0;
        grant_idx = '0;
        for (int k = 1; k <= NUM_REQS; k++) begin
            cand     = (int'(last_ptr) + k) % NUM_REQS;
            cand_idx = LOG_REQS'(cand);
            if (!grant_any && eligible[cand_idx]) begin
                grant_any = 1'b1;
                grant_idx = cand_idx;
            end
        end
    end

    assign stage_free = !bus.mem_req_valid_out || bus.mem_req_ready_out;
    assign grant      = reset && stage_free && grant_any;

    // One-hot accept to the winner; held low throughout reset
    always_comb begin
        grant_onehot = '0;
        if (grant) begin
            grant_onehot[grant_idx] = 1'b1;
        end
    end

    assign bus.req_ready_in = grant_onehot;

    // Output stage valid: load on grant, drain when downstream accepts
    always_ff @(posedge clk) begin
        if (!reset) begin
            bus.mem_req_valid_out <= 1'b0;
        end else if (grant) begin
            bus.mem_req_valid_out <= 1'b1;
        end else if (bus.mem_req_ready_out) begin
            bus.mem_req_valid_out <= 1'b0;
        end
    end

    // Output stage payload; only meaningful while valid, so no reset needed
    always_ff @(posedge clk) begin
        if (grant) begin
            bus.mem_req_rw_out     <= bus.req_rw_in[grant_idx];
            bus.mem_req_addr_out   <= bus.req_addr_in[grant_idx*ADDR_WIDTH +: ADDR_WIDTH];
            bus.mem_req_byteen_out <= bus.req_byteen_in[grant_idx*BYTEEN_WIDTH +: BYTEEN_WIDTH];
            bus.mem_req_data_out   <= bus.req_data_in[grant_idx*DATA_WIDTH +: DATA_WIDTH];
            bus.mem_req_tag_out    <= {bus.req_tag_in[grant_idx*TAG_IN_WIDTH +: TAG_IN_WIDTH], grant_idx};
        end
    end

    // Round-robin pointer remembers the most recent winner
    always_ff @(posedge clk) begin
        if (!reset) begin
            last_ptr <= LOG_REQS'(NUM_REQS - 1);
        end else if (grant) begin
            last_ptr <= grant_idx;
        end
    end

    assign rsp_idx = bus.mem_rsp_tag_out[LOG_REQS-1:0];

    generate
        if ((1 << LOG_REQS) == NUM_REQS) begin : g_idx_full
            assign rsp_idx_ok = 1'b1;
        end else begin : g_idx_part
            assign rsp_idx_ok = (int'(rsp_idx) < NUM_REQS);
        end
    endgenerate

    // Route the response back to the requester named in the low tag bits
    always_comb begin
        rsp_route             = '0;
        bus.mem_rsp_ready_out = 1'b0;
        if (rsp_idx_ok) begin
            rsp_route[rsp_idx]    = bus.mem_rsp_valid_out;
            bus.mem_rsp_ready_out = bus.rsp_ready_in[rsp_idx];
        end
    end

    assign bus.rsp_valid_in = rsp_route;
    assign bus.rsp_data_in  = {NUM_REQS{bus.mem_rsp_data_out}};
    assign bus.rsp_tag_in   = {NUM_REQS{bus.mem_rsp_tag_out[TAG_OUT_WIDTH-1:LOG_REQS]}};
    assign rsp_fire         = bus.mem_rsp_valid_out && bus.mem_rsp_ready_out;

    assign cnt_inc = grant_onehot & ~bus.req_rw_in;
    assign cnt_dec = rsp_fire ? rsp_route : '0;

    // Outstanding-read credits; a read issued and a response returned together cancel
    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int i = 0; i < NUM_REQS; i++) begin
                pend_cnt[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_REQS; i++) begin
                if (cnt_inc[i] && !cnt_dec[i]) begin
                    pend_cnt[i] <= pend_cnt[i] + CNT_WIDTH'(1);
                end else if (cnt_dec[i] && !cnt_inc[i]) begin
                    pend_cnt[i] <= pend_cnt[i] - CNT_WIDTH'(1);
                end
            end
        end
    end

    // Flag responses that cannot belong to any outstanding read
    always_ff @(posedge clk) begin
        if (reset && bus.mem_rsp_valid_out) begin
            assert (rsp_idx_ok) else $error("response tag index out of range");
            if (rsp_fire && rsp_idx_ok) begin
                assert (pend_cnt[rsp_idx] != '0) else $error("response with no outstanding read");
            end
        end
    end
endmodule
